// File: rtl/mux_rr_scheduler.sv
// Round-robin scheduler sharing one P:1 single-bit mux among P requesters.
// Bursts of up to MAX_HOLD beats per grant, valid/ready output handshake.
module mux_rr_scheduler #(
  parameter int N        = 3,
  parameter int P        = 2**N,
  parameter int MAX_HOLD = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [P-1:0] req,
  input  logic [P-1:0] in,
  input  logic         out_ready,
  output logic         y,
  output logic         y_valid,
  output logic [N-1:0] sel,
  output logic [P-1:0] grant,
  output logic         busy
);

  localparam int HW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam logic [HW-1:0] LAST = HW'(MAX_HOLD - 1);
  localparam logic [P-1:0] ONE = {{(P-1){1'b0}}, 1'b1};

  typedef enum logic {IDLE, GRANT} state_t;

  state_t        state, state_n;
  logic [N-1:0]  sel_n;
  logic [N-1:0]  ptr, ptr_n;
  logic [P-1:0]  grant_n;
  logic [HW-1:0] hold_cnt, hold_n;

  logic [N-1:0]  win;
  logic [N-1:0]  idx;
  logic          found;
  logic          xfer;

  assign y       = in[sel];
  assign busy    = (state == GRANT);
  assign y_valid = busy & req[sel];
  assign xfer    = y_valid & out_ready;

  // Search starts at ptr; N-bit addition wraps modulo P.
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = '0;
    for (int k = 0; k < P; k++) begin
      idx = ptr + N'(k);
      if (!found && req[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  always_comb begin
    state_n = state;
    sel_n   = sel;
    grant_n = grant;
    ptr_n   = ptr;
    hold_n  = hold_cnt;
    unique case (state)
      IDLE: begin
        if (found) begin
          state_n = GRANT;
          sel_n   = win;
          grant_n = ONE << win;
          hold_n  = '0;
        end
      end
      GRANT: begin
        if ((xfer && hold_cnt == LAST) || !req[sel]) begin
          state_n = IDLE;
          grant_n = '0;
          ptr_n   = sel + 1'b1;
          hold_n  = '0;
        end else if (xfer) begin
          hold_n = hold_cnt + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      sel      <= '0;
      grant    <= '0;
      ptr      <= '0;
      hold_cnt <= '0;
    end else begin
      state    <= state_n;
      sel      <= sel_n;
      grant    <= grant_n;
      ptr      <= ptr_n;
      hold_cnt <= hold_n;
    end
  end

endmodule

// File: tb/tb_mux_rr_scheduler.sv
// Directed testbench for mux_rr_scheduler.
// Inputs change on the falling edge; outputs are sampled 1ns later.
module tb_mux_rr_scheduler;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] req;
  logic [7:0] in;
  logic       out_ready;
  logic       y;
  logic       y_valid;
  logic [2:0] sel;
  logic [7:0] grant;
  logic       busy;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mux_rr_scheduler #(.N(3), .P(8), .MAX_HOLD(4)) dut (
    .clk(clk), .rst(rst), .req(req), .in(in),
    .out_ready(out_ready), .y(y), .y_valid(y_valid),
    .sel(sel), .grant(grant), .busy(busy)
  );

  task automatic do_reset;
    @(negedge clk);
    rst = 1'b1; req = '0; in = '0; out_ready = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset;
    @(negedge clk);
    rst = 1'b1; req = 8'hFF; in = '0; out_ready = 1'b1;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk); #1;
      n_cmp++;
      if (grant !== 8'h00 || y_valid !== 1'b0 || busy !== 1'b0 || sel !== 3'd0) begin
        n_err++;
        $display("FAIL reset_hold c%0d: grant=%h yv=%b busy=%b sel=%0d, want 00/0/0/0",
                 c, grant, y_valid, busy, sel);
      end
    end
    @(negedge clk);
    rst = 1'b0; #1;
    n_cmp++;
    if (grant !== 8'h00 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL reset_release_idle: grant=%h busy=%b, want 00/0", grant, busy);
    end
    @(negedge clk); #1;
    n_cmp++;
    if (grant !== 8'h01 || sel !== 3'd0 || busy !== 1'b1) begin
      n_err++;
      $display("FAIL reset_first_grant: grant=%h sel=%0d busy=%b, want 01/0/1", grant, sel, busy);
    end
  endtask

  task automatic test_single;
    logic [7:0] eg [7];
    logic       ev [7];
    eg = '{8'h00, 8'h04, 8'h04, 8'h04, 8'h04, 8'h00, 8'h04};
    ev = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    do_reset();
    req = 8'h04; in = 8'h04; out_ready = 1'b1;
    for (int c = 0; c < 7; c++) begin
      #1;
      n_cmp++;
      if (grant !== eg[c] || y_valid !== ev[c]) begin
        n_err++;
        $display("FAIL single c%0d: grant=%h yv=%b, want %h/%b", c, grant, y_valid, eg[c], ev[c]);
      end
      if (c != 0) begin
        n_cmp++;
        if (sel !== 3'd2 || y !== 1'b1) begin
          n_err++;
          $display("FAIL single_sel c%0d: sel=%0d y=%b, want 2/1", c, sel, y);
        end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_rr;
    logic [7:0] eg;
    logic       ev;
    int         g;
    do_reset();
    req = 8'hFF; in = 8'hA5; out_ready = 1'b1;
    for (int c = 0; c < 42; c++) begin
      #1;
      g  = ((c - 1) / 5) % 8;
      ev = (c % 5 != 0);
      eg = ev ? (8'h01 << g) : 8'h00;
      n_cmp++;
      if (grant !== eg || y_valid !== ev) begin
        n_err++;
        $display("FAIL rr c%0d: grant=%h yv=%b, want %h/%b", c, grant, y_valid, eg, ev);
      end
      if (ev) begin
        n_cmp++;
        if (sel !== 3'(g) || y !== in[g]) begin
          n_err++;
          $display("FAIL rr_sel c%0d: sel=%0d y=%b, want %0d/%b", c, sel, y, g, in[g]);
        end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_backpressure;
    logic rdy [8];
    logic [7:0] eg [8];
    rdy = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    eg  = '{8'h00, 8'h20, 8'h20, 8'h20, 8'h20, 8'h20, 8'h20, 8'h00};
    do_reset();
    req = 8'h20; in = 8'h20;
    for (int c = 0; c < 8; c++) begin
      out_ready = rdy[c];
      #1;
      n_cmp++;
      if (grant !== eg[c] || busy !== (eg[c] != 8'h00)) begin
        n_err++;
        $display("FAIL backpressure c%0d: grant=%h busy=%b, want %h", c, grant, busy, eg[c]);
      end
      @(negedge clk);
    end
    n_cmp++;
    if (sel !== 3'd5) begin
      n_err++;
      $display("FAIL backpressure_sel: sel=%0d, want 5", sel);
    end
  endtask

  task automatic test_withdraw;
    do_reset();
    req = 8'h18; in = 8'hFF; out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    req = 8'h10; #1;
    n_cmp++;
    if (y_valid !== 1'b0 || grant !== 8'h08 || busy !== 1'b1) begin
      n_err++;
      $display("FAIL withdraw_drop: yv=%b grant=%h busy=%b, want 0/08/1", y_valid, grant, busy);
    end
    @(negedge clk);
    req = 8'h18; #1;
    n_cmp++;
    if (grant !== 8'h00 || busy !== 1'b0 || sel !== 3'd3) begin
      n_err++;
      $display("FAIL withdraw_idle: grant=%h busy=%b sel=%0d, want 00/0/3", grant, busy, sel);
    end
    @(negedge clk); #1;
    n_cmp++;
    if (grant !== 8'h10 || sel !== 3'd4) begin
      n_err++;
      $display("FAIL withdraw_next: grant=%h sel=%0d, want 10/4", grant, sel);
    end
  endtask

  task automatic test_reset_mid;
    do_reset();
    req = 8'h20; in = 8'hFF; out_ready = 1'b1;
    @(negedge clk);
    req = 8'h40;
    @(negedge clk);
    @(negedge clk); #1;
    n_cmp++;
    if (grant !== 8'h40 || sel !== 3'd6) begin
      n_err++;
      $display("FAIL rstmid_grant6: grant=%h sel=%0d, want 40/6", grant, sel);
    end
    @(negedge clk);
    rst = 1'b1; #1;
    n_cmp++;
    if (grant !== 8'h40 || busy !== 1'b1) begin
      n_err++;
      $display("FAIL rstmid_beat2: grant=%h busy=%b, want 40/1", grant, busy);
    end
    @(negedge clk);
    rst = 1'b0; req = 8'h44; #1;
    n_cmp++;
    if (grant !== 8'h00 || sel !== 3'd0 || busy !== 1'b0 || y_valid !== 1'b0) begin
      n_err++;
      $display("FAIL rstmid_after: grant=%h sel=%0d busy=%b yv=%b, want 00/0/0/0",
               grant, sel, busy, y_valid);
    end
    @(negedge clk); #1;
    n_cmp++;
    if (grant !== 8'h04 || sel !== 3'd2) begin
      n_err++;
      $display("FAIL rstmid_regrant: grant=%h sel=%0d, want 04/2", grant, sel);
    end
  endtask

  initial begin
    rst = 1'b1; req = '0; in = '0; out_ready = 1'b0;
    test_reset();
    test_single();
    test_rr();
    test_backpressure();
    test_withdraw();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mux_rr_scheduler.md
Name: mux_rr_scheduler

Overview:
- Round-robin scheduler that shares one P:1 single-bit mux output among P requesters.
- Each requester raises a request and presents its data bit on its mux input. The scheduler drives the mux select, grants one requester per burst of up to MAX_HOLD beats, and presents the selected bit with a valid/ready handshake to a single downstream consumer.
- The block contains its own mux, with select driven from a registered select register.

Parameters:
- N, 3, select width.
- P, 2**N, number of requesters / mux inputs.
- MAX_HOLD, 4, maximum beats transferred per grant (at least 1).

Ports:
- clk  input  1  sole clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- req  input  P  per-requester request; bit i = requester i wants the output.
- in  input  P  mux data inputs; bit i = current data bit of requester i.
- out_ready  input  1  downstream accepts a beat this cycle.
- y  output  1  selected data bit, equal to in[sel] (combinational through the mux).
- y_valid  output  1  beat on y is valid.
- sel  output  N  registered mux select; index of current/last grantee.
- grant  output  P  one-hot grant; all zero when idle.
- busy  output  1  high while in GRANT state.

Behaviour:
- Reset (rst=1 at rising edge), synchronous, overriding all else:
  - State = IDLE; sel=0, grant=0, ptr=0, hold_cnt=0.
  - Outputs: y_valid=0, busy=0. y follows in[0].
  - A reset mid-grant drops grant at that same edge; the in-flight beat is not completed.
- State machine, two states: IDLE, GRANT.
- IDLE:
  - If req==0, remain in IDLE.
  - Otherwise choose winner w = first index with req[w]=1, searching ptr, ptr+1, ..., P-1, 0, ..., ptr-1 (modulo P).
  - Next edge: sel<=w, grant<=one-hot(w), hold_cnt<=0, state<=GRANT.
  - Latency: req rises in cycle t, grant visible in cycle t+1.
- GRANT:
  - y_valid = req[sel]; grant and busy held high.
  - A beat transfers on a cycle with y_valid=1 and out_ready=1; hold_cnt increments on each transfer.
  - Release condition A: a transfer with hold_cnt==MAX_HOLD-1 (burst limit reached).
  - Release condition B: req[sel]==0 (requester withdrew); y_valid is 0, so no transfer occurs.
  - On release, next edge: state<=IDLE, grant<=0, ptr<=(sel+1) mod P, hold_cnt<=0. sel keeps its value.
  - Otherwise remain in GRANT. out_ready low stalls without counting.
- Turnaround: every release spends exactly one cycle in IDLE before the next grant. Maximum throughput is MAX_HOLD beats per MAX_HOLD+1 cycles.
- Fairness: the pointer advances past the last grantee, so a continuously requesting requester waits at most P-1 other grants.
- Wrap-around: ptr = P-1 followed by a release gives ptr = 0. The search wraps modulo P; width-N arithmetic overflow provides the wrap because P = 2**N.
- Simultaneous events:
  - Transfer on the limit beat while req[sel] drops in the same cycle: condition A applies, one release.
  - req changes in other bits during GRANT are ignored until the next IDLE.
- in[] is not registered: y reflects the grantee's data in the transfer cycle.
- sel changes only on the IDLE->GRANT edge or on reset, never mid-burst.

Test Plan:
- Reset: hold rst=1 for 2 cycles with req=8'hFF -> grant=0, y_valid=0, busy=0, sel=0. Release rst -> grant=8'h01 one cycle later.
- Single requester burst: req=8'b00000100, in=8'b00000100, out_ready=1 -> grant=8'h04, sel=2, y=1, y_valid for 4 cycles. Then 1 IDLE cycle, then re-grant to 2 (ptr=3 wraps search back to 2).
- Round robin: req=8'hFF, out_ready=1 -> grants in order sel=0,1,2,...,7,0. Each burst is 4 beats with 1 bubble; 8 grants take 40 cycles.
- Backpressure: grant to requester 5, out_ready toggles 1,0,0,1,1,1 -> exactly 4 transfers counted; release after the 6th cycle; hold_cnt does not advance on stall cycles.
- Withdrawal: requester 3 granted; drop req[3] after 2 transfers -> y_valid=0 that cycle, next edge IDLE, ptr=4. Requester 4 (if requesting) granted next, before 3.
- Reset mid-burst: assert rst during the 2nd beat of a grant to requester 6 -> grant=0, sel=0, ptr=0 after that edge. Next grant after rst deasserts goes to the lowest requesting index.
